// File: rtl/board_cursor_ctrl_if.sv
// -----------------------------------------------------------------------------
// board_cursor_ctrl_if
// Groups the signals between the button synchronizers, the VGA timing block,
// the renderer and board_cursor_ctrl.
//   btn_up/down/left/right/sel : synchronized button levels, 1 = pressed
//   vblank                     : 1 during vertical blanking
//   i_actual / j_actual        : registered cursor row / column
//   sel_valid                  : one-cycle select pulse
//   sel_i / sel_j              : position captured at select (while sel_valid)
//   locked                     : 1 while the controller ignores input after a select
// master = the environment that drives buttons/vblank; slave = the controller.
// -----------------------------------------------------------------------------
interface board_cursor_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_sel;
   logic       vblank;
   logic [2:0] i_actual;
   logic [2:0] j_actual;
   logic       sel_valid;
   logic [2:0] sel_i;
   logic [2:0] sel_j;
   logic       locked;

   modport master (
      output btn_up, btn_down, btn_left, btn_right, btn_sel, vblank,
      input  i_actual, j_actual, sel_valid, sel_i, sel_j, locked
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right, btn_sel, vblank,
      output i_actual, j_actual, sel_valid, sel_i, sel_j, locked
   );
endinterface

// File: rtl/board_cursor_ctrl.sv
// -----------------------------------------------------------------------------
// board_cursor_ctrl
// Frame-synchronous cursor controller for the board renderer. Button presses
// (rising edges) and held-button auto-repeat become move/select commands that
// are applied only on the rising edge of vblank, so a frame never shows two
// cursor positions. After a select, all input is ignored for LOCK_FRAMES.
// Ports:
//   clk  : pixel clock
//   rst  : synchronous, active-high reset
//   bus  : board_cursor_ctrl_if.slave (buttons, vblank in; cursor/select out)
// -----------------------------------------------------------------------------
module board_cursor_ctrl #(
   parameter int BOARD_SIZE    = 5,
   parameter int REPEAT_FRAMES = 20,
   parameter int REPEAT_RATE   = 6,
   parameter int LOCK_FRAMES   = 30
) (
   input  logic                clk,
   input  logic                rst,
   board_cursor_ctrl_if.slave  bus
);

   localparam int CNT_MAX = (REPEAT_FRAMES > LOCK_FRAMES) ? REPEAT_FRAMES : LOCK_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   // Counters compare against "last" values: the terminal action fires on the
   // tick where the count has already reached target-1.
   localparam logic [CNT_W-1:0] FIRST_LAST = CNT_W'(REPEAT_FRAMES - 1);
   localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
   localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'(LOCK_FRAMES - 1);
   localparam logic [2:0]       IDX_LAST   = 3'(BOARD_SIZE - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_PENDING, ST_LOCK} state_t;
   typedef enum logic [2:0] {CMD_NONE, CMD_SEL, CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT} cmd_t;

   state_t           r_state;
   cmd_t             r_pend_cmd;
   cmd_t             r_hold_cmd;
   logic             r_hold_act;
   logic             r_repeat;
   logic [CNT_W-1:0] r_hold_cnt;
   logic [CNT_W-1:0] r_lock_cnt;
   logic             r_vblank_prev;
   logic [4:0]       r_btn_prev;
   logic [4:0]       r_press;
   logic [2:0]       r_i;
   logic [2:0]       r_j;
   logic             r_sel_valid;
   logic [2:0]       r_sel_i;
   logic [2:0]       r_sel_j;
   logic             r_locked;

   logic [4:0]       w_btn;
   logic             w_frame_tick;
   cmd_t             w_press_cmd;
   logic             w_held;
   logic [CNT_W-1:0] w_hold_last;

   // Bit order doubles as priority order: sel > up > down > left > right.
   assign w_btn        = {bus.btn_sel, bus.btn_up, bus.btn_down, bus.btn_left, bus.btn_right};
   assign w_frame_tick = bus.vblank & ~r_vblank_prev;
   assign w_hold_last  = r_repeat ? RATE_LAST : FIRST_LAST;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      w_press_cmd = CMD_NONE;
      if      (r_press[4]) w_press_cmd = CMD_SEL;
      else if (r_press[3]) w_press_cmd = CMD_UP;
      else if (r_press[2]) w_press_cmd = CMD_DOWN;
      else if (r_press[1]) w_press_cmd = CMD_LEFT;
      else if (r_press[0]) w_press_cmd = CMD_RIGHT;
   end

   always_comb begin
      w_held = 1'b0;
      case (r_hold_cmd)
         CMD_UP:    w_held = bus.btn_up;
         CMD_DOWN:  w_held = bus.btn_down;
         CMD_LEFT:  w_held = bus.btn_left;
         CMD_RIGHT: w_held = bus.btn_right;
         default:   w_held = 1'b0;
      endcase
   end

   // NOTE: all state below is updated with non-blocking assignments so every
   // register samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_pend_cmd    <= CMD_NONE;
         r_hold_cmd    <= CMD_NONE;
         r_hold_act    <= 1'b0;
         r_repeat      <= 1'b0;
         r_hold_cnt    <= '0;
         r_lock_cnt    <= '0;
         r_vblank_prev <= 1'b0;
         r_btn_prev    <= '0;
         r_press       <= '0;
         r_i           <= '0;
         r_j           <= '0;
         r_sel_valid   <= 1'b0;
         r_sel_i       <= '0;
         r_sel_j       <= '0;
         r_locked      <= 1'b0;
      end else begin
         r_vblank_prev <= bus.vblank;
         r_btn_prev    <= w_btn;
         r_press       <= w_btn & ~r_btn_prev;
         r_sel_valid   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_press_cmd != CMD_NONE) begin
                  r_pend_cmd <= w_press_cmd;
                  r_state    <= ST_PENDING;
                  // A new press restarts hold tracking; select never repeats.
                  r_hold_act <= (w_press_cmd != CMD_SEL);
                  r_hold_cmd <= w_press_cmd;
                  r_hold_cnt <= '0;
                  r_repeat   <= 1'b0;
               end else if (r_hold_act) begin
                  if (!w_held) begin
                     r_hold_act <= 1'b0;
                     r_hold_cnt <= '0;
                  end else if (w_frame_tick) begin
                     if (r_hold_cnt >= w_hold_last) begin
                        r_pend_cmd <= r_hold_cmd;
                        r_state    <= ST_PENDING;
                        r_hold_cnt <= '0;
                        r_repeat   <= 1'b1;
                     end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                     end
                  end
               end
            end

            ST_PENDING: begin
               // Hold counting continues here so repeats keep an exact frame cadence.
               if (r_hold_act) begin
                  if (!w_held) begin
                     r_hold_act <= 1'b0;
                     r_hold_cnt <= '0;
                  end else if (w_frame_tick && (r_hold_cnt < w_hold_last)) begin
                     r_hold_cnt <= r_hold_cnt + 1'b1;
                  end
               end
               if (w_frame_tick) begin
                  r_state <= ST_IDLE;
                  case (r_pend_cmd)
                     CMD_UP:    r_i <= (r_i == 3'd0)     ? IDX_LAST : r_i - 3'd1;
                     CMD_DOWN:  r_i <= (r_i == IDX_LAST) ? 3'd0     : r_i + 3'd1;
                     CMD_LEFT:  r_j <= (r_j == 3'd0)     ? IDX_LAST : r_j - 3'd1;
                     CMD_RIGHT: r_j <= (r_j == IDX_LAST) ? 3'd0     : r_j + 3'd1;
                     CMD_SEL: begin
                        r_sel_valid <= 1'b1;
                        r_sel_i     <= r_i;
                        r_sel_j     <= r_j;
                        r_lock_cnt  <= '0;
                        r_locked    <= 1'b1;
                        r_state     <= ST_LOCK;
                     end
                     default: ;
                  endcase
                  r_pend_cmd <= CMD_NONE;
               end
            end

            ST_LOCK: begin
               // Held buttons never re-arm: only a fresh edge after LOCK counts.
               r_hold_act <= 1'b0;
               r_hold_cnt <= '0;
               if (w_frame_tick) begin
                  if (r_lock_cnt >= LOCK_LAST) begin
                     r_state  <= ST_IDLE;
                     r_locked <= 1'b0;
                  end else begin
                     r_lock_cnt <= r_lock_cnt + 1'b1;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.i_actual  = r_i;
   assign bus.j_actual  = r_j;
   assign bus.sel_valid = r_sel_valid;
   assign bus.sel_i     = r_sel_i;
   assign bus.sel_j     = r_sel_j;
   assign bus.locked    = r_locked;

endmodule
